pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 14 +
 rtl/pipe_hazard_det.sv | 17 +
 rtl/pipe_ctrl.sv | 168 ++++++++++++++++
 tb/tb_pipe_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
package pipe_ctrl_pkg;

  localparam int unsigned REG_W       = 5;
  localparam int unsigned MDU_LAT_DEF = 4;
  localparam int unsigned MDU_CNT_W   = 4;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MDU_BUSY = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_e;

endpackage

// File: rtl/pipe_hazard_det.sv
// Load-use hazard compare between the load in EX and the instruction in ID.
module pipe_hazard_det
  import pipe_ctrl_pkg::*;
(
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  output logic             load_use
);

  // Register 0 is hardwired, so a load targeting it never creates a hazard.
  assign load_use = ex_mem_read && (ex_rt != REG_W'(0)) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: memory wait, branch flush, MDU occupancy, load-use.
// Optional PIPE_CTRL_PERF_EN adds saturating stall/flush performance counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned MDU_LAT = MDU_LAT_DEF,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             id_uses_rt_i,
  input  logic             ex_mem_read_i,
  input  logic [REG_W-1:0] ex_rt_i,
  input  logic             ex_branch_taken_i,
  input  logic             ex_mdu_i,
  input  logic             mem_req_i,
  input  logic             dmem_ready_i,
  output logic             pc_hold_o,
  output logic             ifid_hold_o,
  output logic             idex_hold_o,
  output logic             exmem_hold_o,
  output logic             ifid_flush_o,
  output logic             idex_flush_o,
  output logic             memwb_flush_o,
  output logic             mdu_done_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
`endif
);

  localparam logic [MDU_CNT_W-1:0] MDU_LOAD = MDU_CNT_W'(MDU_LAT - 2);

  if (MDU_LAT < 2 || MDU_LAT > 16 || CNT_W < 1) begin : g_param_check
    $error("pipe_ctrl: illegal parameter value");
  end

  state_e               state, state_nxt, eff_state;
  logic                 ret_busy, ret_busy_nxt;
  logic [MDU_CNT_W-1:0] cnt, cnt_nxt;
  logic                 mem_wait;
  logic                 load_use;

  assign mem_wait = mem_req_i && !dmem_ready_i;

  pipe_hazard_det u_hazard (
    .ex_mem_read (ex_mem_read_i),
    .ex_rt       (ex_rt_i),
    .id_rs       (id_rs_i),
    .id_rt       (id_rt_i),
    .id_uses_rt  (id_uses_rt_i),
    .load_use    (load_use)
  );

  // Once memory is ready, the MEM_WAIT cycle already behaves as the saved state.
  always_comb begin
    eff_state = state;
    if (state == ST_MEM_WAIT) eff_state = ret_busy ? ST_MDU_BUSY : ST_RUN;
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      ret_busy <= 1'b0;
      cnt      <= '0;
    end else begin
      state    <= state_nxt;
      ret_busy <= ret_busy_nxt;
      cnt      <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = eff_state;
    ret_busy_nxt = ret_busy;
    cnt_nxt      = cnt;
    if (mem_wait) begin
      state_nxt = ST_MEM_WAIT;
      if (state != ST_MEM_WAIT) ret_busy_nxt = (state == ST_MDU_BUSY);
    end else begin
      case (eff_state)
        ST_RUN: begin
          if (!ex_branch_taken_i && ex_mdu_i && (MDU_LAT > 2)) begin
            state_nxt = ST_MDU_BUSY;
            cnt_nxt   = MDU_LOAD;
          end
        end
        ST_MDU_BUSY: begin
          cnt_nxt = cnt - MDU_CNT_W'(1);
          if (cnt == MDU_CNT_W'(1)) state_nxt = ST_RUN;
        end
        default: state_nxt = ST_RUN;
      endcase
    end
  end

  // Output decode; reset forces every output low at once.
  always_comb begin
    pc_hold_o     = 1'b0;
    ifid_hold_o   = 1'b0;
    idex_hold_o   = 1'b0;
    exmem_hold_o  = 1'b0;
    ifid_flush_o  = 1'b0;
    idex_flush_o  = 1'b0;
    memwb_flush_o = 1'b0;
    mdu_done_o    = 1'b0;
    if (mem_wait) begin
      pc_hold_o     = 1'b1;
      ifid_hold_o   = 1'b1;
      idex_hold_o   = 1'b1;
      exmem_hold_o  = 1'b1;
      memwb_flush_o = 1'b1;
    end else begin
      case (eff_state)
        ST_RUN: begin
          if (ex_branch_taken_i) begin
            ifid_flush_o = 1'b1;
            idex_flush_o = 1'b1;
          end else if (ex_mdu_i) begin
            pc_hold_o   = 1'b1;
            ifid_hold_o = 1'b1;
            idex_hold_o = 1'b1;
            mdu_done_o  = (MDU_LAT == 2);
          end else if (load_use) begin
            pc_hold_o    = 1'b1;
            ifid_hold_o  = 1'b1;
            idex_flush_o = 1'b1;
          end
        end
        ST_MDU_BUSY: begin
          pc_hold_o   = 1'b1;
          ifid_hold_o = 1'b1;
          idex_hold_o = 1'b1;
          mdu_done_o  = (cnt == MDU_CNT_W'(1));
        end
        default: ;
      endcase
    end
    if (!rst_n) begin
      pc_hold_o     = 1'b0;
      ifid_hold_o   = 1'b0;
      idex_hold_o   = 1'b0;
      exmem_hold_o  = 1'b0;
      ifid_flush_o  = 1'b0;
      idex_flush_o  = 1'b0;
      memwb_flush_o = 1'b0;
      mdu_done_o    = 1'b0;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  // Saturating counters of stalled cycles and cycles with any bubble inserted.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (pc_hold_o && (stall_cnt_o != '1)) stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      if ((ifid_flush_o || idex_flush_o || memwb_flush_o) && (flush_cnt_o != '1))
        flush_cnt_o <= flush_cnt_o + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (default MDU_LAT=4, CNT_W=16).
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rt, ex_mem_read, ex_branch_taken, ex_mdu, mem_req, dmem_ready;
  logic       pc_hold, ifid_hold, idex_hold, exmem_hold;
  logic       ifid_flush, idex_flush, memwb_flush, mdu_done;
`ifdef PIPE_CTRL_PERF_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  int total = 0;
  int bad   = 0;

  // Output vector order: pc, ifid, idex, exmem holds; ifid, idex, memwb flushes; mdu_done
  localparam logic [7:0] O_NONE = 8'b0000_0000;
  localparam logic [7:0] O_LU   = 8'b1100_0100;
  localparam logic [7:0] O_BR   = 8'b0000_1100;
  localparam logic [7:0] O_MW   = 8'b1111_0010;
  localparam logic [7:0] O_MDU  = 8'b1110_0000;
  localparam logic [7:0] O_DONE = 8'b1110_0001;

  always #5 clk = ~clk;

  pipe_ctrl dut (
    .clk_i             (clk),
    .rst_n             (rst_n),
    .id_rs_i           (id_rs),
    .id_rt_i           (id_rt),
    .id_uses_rt_i      (id_uses_rt),
    .ex_mem_read_i     (ex_mem_read),
    .ex_rt_i           (ex_rt),
    .ex_branch_taken_i (ex_branch_taken),
    .ex_mdu_i          (ex_mdu),
    .mem_req_i         (mem_req),
    .dmem_ready_i      (dmem_ready),
    .pc_hold_o         (pc_hold),
    .ifid_hold_o       (ifid_hold),
    .idex_hold_o       (idex_hold),
    .exmem_hold_o      (exmem_hold),
    .ifid_flush_o      (ifid_flush),
    .idex_flush_o      (idex_flush),
    .memwb_flush_o     (memwb_flush),
    .mdu_done_o        (mdu_done)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .stall_cnt_o       (stall_cnt),
    .flush_cnt_o       (flush_cnt)
`endif
  );

  typedef struct {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       mem_read;
    logic [4:0] ex_rt;
    logic       br;
    logic       mem_req;
    logic       ready;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string nm, input logic [7:0] exp);
    logic [7:0] act;
    #1;
    act = {pc_hold, ifid_hold, idex_hold, exmem_hold, ifid_flush, idex_flush, memwb_flush, mdu_done};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic idle();
    id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; ex_mem_read = 1'b0; ex_rt = '0;
    ex_branch_taken = 1'b0; ex_mdu = 1'b0; mem_req = 1'b0; dmem_ready = 1'b1;
  endtask

  initial begin
    //        rs     rt     uses  mread ex_rt  br    mreq  rdy   exp
    tbl[0]  = '{5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, O_NONE};
    tbl[1]  = '{5'd9,  5'd0,  1'b0, 1'b1, 5'd9,  1'b0, 1'b0, 1'b1, O_LU};
    tbl[2]  = '{5'd0,  5'd0,  1'b1, 1'b1, 5'd0,  1'b0, 1'b0, 1'b1, O_NONE};
    tbl[3]  = '{5'd3,  5'd9,  1'b1, 1'b1, 5'd9,  1'b0, 1'b0, 1'b1, O_LU};
    tbl[4]  = '{5'd3,  5'd9,  1'b0, 1'b1, 5'd9,  1'b0, 1'b0, 1'b1, O_NONE};
    tbl[5]  = '{5'd9,  5'd0,  1'b0, 1'b0, 5'd9,  1'b0, 1'b0, 1'b1, O_NONE};
    tbl[6]  = '{5'd9,  5'd0,  1'b0, 1'b1, 5'd9,  1'b1, 1'b0, 1'b1, O_BR};
    tbl[7]  = '{5'd4,  5'd5,  1'b1, 1'b0, 5'd7,  1'b1, 1'b0, 1'b1, O_BR};
    tbl[8]  = '{5'd9,  5'd0,  1'b0, 1'b1, 5'd9,  1'b0, 1'b1, 1'b1, O_LU};
    tbl[9]  = '{5'd9,  5'd0,  1'b0, 1'b1, 5'd9,  1'b1, 1'b1, 1'b0, O_MW};
    tbl[10] = '{5'd9,  5'd0,  1'b0, 1'b1, 5'd9,  1'b0, 1'b0, 1'b1, O_LU};
    tbl[11] = '{5'd31, 5'd0,  1'b0, 1'b1, 5'd31, 1'b0, 1'b0, 1'b1, O_LU};

    // Reset: outputs low even while a memory wait is presented
    idle();
    mem_req = 1'b1; dmem_ready = 1'b0; ex_mdu = 1'b1;
    rst_n = 1'b0;
    #2 chk("reset_outputs", O_NONE);
`ifdef PIPE_CTRL_PERF_EN
    chk16("reset_stall_cnt", stall_cnt, 16'h0000);
    chk16("reset_flush_cnt", flush_cnt, 16'h0000);
`endif
    @(negedge clk); idle(); rst_n = 1'b1;
    chk("post_reset_idle", O_NONE);

    // Single-cycle combinational vectors from RUN
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      id_rs = tbl[i].rs; id_rt = tbl[i].rt; id_uses_rt = tbl[i].uses_rt;
      ex_mem_read = tbl[i].mem_read; ex_rt = tbl[i].ex_rt; ex_branch_taken = tbl[i].br;
      ex_mdu = 1'b0; mem_req = tbl[i].mem_req; dmem_ready = tbl[i].ready;
      chk($sformatf("vec%0d", i), tbl[i].exp);
    end

    // MDU occupancy, MDU_LAT=4: three hold cycles, done in the third
    @(negedge clk); idle(); ex_mdu = 1'b1; chk("mdu_c0", O_MDU);
    @(negedge clk); chk("mdu_c1", O_MDU);
    @(negedge clk); chk("mdu_c2_done", O_DONE);
    @(negedge clk); idle(); chk("mdu_after", O_NONE);
    @(negedge clk); ex_mem_read = 1'b1; ex_rt = 5'd9; id_rs = 5'd9; chk("mdu_after_lu", O_LU);

    // Two-cycle memory wait inside MDU_BUSY freezes the counter: five holds total
    @(negedge clk); idle(); ex_mdu = 1'b1; chk("mdu_mw_c0", O_MDU);
    @(negedge clk); mem_req = 1'b1; dmem_ready = 1'b0; chk("mdu_mw_c1_wait", O_MW);
    @(negedge clk); chk("mdu_mw_c2_wait", O_MW);
    @(negedge clk); dmem_ready = 1'b1; chk("mdu_mw_c3_busy", O_MDU);
    @(negedge clk); mem_req = 1'b0; chk("mdu_mw_c4_done", O_DONE);
    @(negedge clk); idle(); chk("mdu_mw_after", O_NONE);

    // Branch beats MDU in the same cycle and MDU_BUSY is not entered
    @(negedge clk); idle(); ex_mdu = 1'b1; ex_branch_taken = 1'b1; chk("br_over_mdu", O_BR);
    @(negedge clk); idle(); chk("br_over_mdu_next", O_NONE);

    // Reset during MDU_BUSY abandons the op
    @(negedge clk); idle(); ex_mdu = 1'b1; chk("rst_mdu_c0", O_MDU);
    @(negedge clk); chk("rst_mdu_c1", O_MDU);
    #2 rst_n = 1'b0; mem_req = 1'b1; dmem_ready = 1'b0;
    chk("rst_mdu_immediate", O_NONE);
    @(negedge clk); idle(); rst_n = 1'b1; chk("rst_mdu_first_run", O_NONE);
    @(negedge clk); ex_mem_read = 1'b1; ex_rt = 5'd9; id_rs = 5'd9; chk("rst_mdu_lu", O_LU);

    // Reset during MEM_WAIT that was saving MDU_BUSY
    @(negedge clk); idle(); ex_mdu = 1'b1; chk("rst_mw_c0", O_MDU);
    @(negedge clk); mem_req = 1'b1; dmem_ready = 1'b0; chk("rst_mw_c1", O_MW);
    @(negedge clk); #2 rst_n = 1'b0; chk("rst_mw_immediate", O_NONE);
    @(negedge clk); idle(); rst_n = 1'b1; chk("rst_mw_first_run", O_NONE);

`ifdef PIPE_CTRL_PERF_EN
    // Long forced stall saturates both counters
    @(negedge clk); idle(); mem_req = 1'b1; dmem_ready = 1'b0;
    repeat (65540) @(negedge clk);
    #1;
    chk16("stall_cnt_sat", stall_cnt, 16'hFFFF);
    chk16("flush_cnt_sat", flush_cnt, 16'hFFFF);
    @(negedge clk); idle();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
